// File: rtl/fa_bist_pkg.sv
// Shared types, constants and the reference full-adder function for the
// full-adder BIST engine and any future checkers of the same interface.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } fa_state_e;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  // Vector bit mapping: cin = v[2], a = v[1], b = v[0]; result is {cout, sum}.
  function automatic logic [1:0] fa_expect(input logic [VEC_W-1:0] v);
    logic cin_v, a_v, b_v;
    cin_v = v[2];
    a_v   = v[1];
    b_v   = v[0];
    return {(a_v & b_v) | (a_v & cin_v) | (b_v & cin_v), a_v ^ b_v ^ cin_v};
  endfunction

endpackage

// File: rtl/fa_golden.sv
// Combinational golden full adder indexed by the 3-bit stimulus vector.
module fa_golden
  import fa_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             cout_exp,
  output logic             sum_exp
);

  assign {cout_exp, sum_exp} = fa_expect(vec);

endmodule

// File: rtl/fa_bist.sv
// Stimulus/response BIST for a 1-bit full adder: walks all 8 input vectors,
// compares COUT/SUM against the golden model and reports the run result.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       cin,
  input  logic       cout,
  input  logic       sum,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VEC - 1);

  fa_state_e        state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d, cin_q, cin_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]       err_q, err_d;
  logic [2:0]       ffv_q, ffv_d;
  logic             cout_exp, sum_exp, mismatch;

  fa_golden u_golden (
    .vec      (vec_q),
    .cout_exp (cout_exp),
    .sum_exp  (sum_exp)
  );

  // A double-bit error still counts as a single failing vector.
  assign mismatch = (cout != cout_exp) || (sum != sum_exp);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d           = DRIVE;
          vec_d             = '0;
          cnt_d             = '0;
          {cin_d, a_d, b_d} = '0;
          busy_d            = 1'b1;
          pass_d            = 1'b0;
          err_d             = '0;
          ffv_d             = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 4'd1;
          if (err_q == 4'd0) begin
            ffv_d = vec_q;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d           = DONE;
          busy_d            = 1'b0;
          done_d            = 1'b1;
          pass_d            = (err_d == 4'd0);
          {cin_d, a_d, b_d} = '0;
        end else begin
          // Stimulus registers load the next vector together with the index.
          vec_d             = vec_q + VEC_W'(1);
          {cin_d, a_d, b_d} = vec_q + VEC_W'(1);
          state_d           = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign cin            = cin_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule
